io_timer_port: RTL and testbench
================================

# io_timer_port

Memory-mapped I/O responder occupying the I/O window (0xD000–0xDFFF) that the address decoder selects with its active-low I/O select. It provides:
- an 8-bit bidirectional GPIO port with per-bit direction control;
- a 16-bit down-counting timer with one-shot and free-run modes;
- an interrupt flag/enable pair driving the CPU's active-low IRQ line.

It is the target-side end of the decoded bus: the decoder asserts the select, and this block decodes the low address bits and completes the read or write.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- cs_n  in  1  chip select from decoder I/O output, active low
- rw  in  1  1 = read, 0 = write
- addr  in  3  register index (CPU address[2:0]); upper window bits are mirrored
- data_in  in  8  write data from CPU
- data_out  out  8  read data
- data_oe  out  1  read-data drive enable
- port_in  in  8  external pin inputs, asynchronous
- port_out  out  8  output register value
- port_oe  out  8  per-bit output enable (= DDRA)
- irq_n  out  1  interrupt request, active low

## Operation
Reset (async, rst_n low) sets every register to 0: ORA, DDRA, LATCH_L, LATCH_H, CNT, running, ACR, IFR, IER, both sync stages, and prev_pin0. Resulting outputs: port_out=0x00, port_oe=0x00, data_out=0x00, data_oe=0, irq_n=1.

- Write strobe: cs_n=0, rw=0, sampled on a clk edge. One register update per cycle.
- Read: data_oe = !cs_n & rw. data_out is combinational from registers while data_oe=1, otherwise 0x00.

Register map (addr):
- 0 ORA:
  - W sets ORA.
  - R returns (ORA & DDRA) | (pin_sync & ~DDRA).
- 1 DDRA: R/W. 1 = output.
- 2 T_LO:
  - W sets LATCH_L.
  - R returns CNT[7:0] and clears IFR[0] at that edge.
- 3 T_HI:
  - W sets LATCH_H, loads CNT = {data_in, LATCH_L}, sets running=1, clears IFR[0].
  - R returns CNT[15:8].
- 4 ACR: bit0 = free-run. Other bits read 0 and are not stored.
- 5 IFR:
  - R returns {|(IFR[1:0] & IER[1:0]), 5'b0, IFR[1:0]}.
  - W: each 1 in data_in[1:0] clears the corresponding flag.
- 6 IER:
  - W with data_in[7]=1 sets the bits given by data_in[1:0]; with data_in[7]=0 clears them.
  - R returns {1'b1, 5'b0, IER[1:0]}.
- 7 reserved: R returns 0x00, W ignored.

Input synchronizer:
- port_in passes through a 2-flop synchronizer to give pin_sync.
- prev_pin0 holds the previous pin_sync[0].

Edge flag:
- IFR[1] is set on a clk edge where prev_pin0=1 and pin_sync[0]=0 (falling edge of pin 0).

Timer (evaluated every edge while running=1, with no T_HI write on that edge):
- CNT != 0: CNT decrements by 1.
- CNT == 0 (underflow):
  - IFR[0] is set.
  - If ACR[0]=1, CNT reloads {LATCH_H, LATCH_L} and running stays 1.
  - If ACR[0]=0, running goes to 0 and CNT stays 0.
- While running=0, CNT holds.

IRQ: irq_n = !(|(IFR[1:0] & IER[1:0])). It is derived only from register state, so it is glitch-free.

## Timing
- Write latency: a register updates at the edge where the write strobe is sampled and is readable on the next cycle.
- Timer latency: a T_HI write of value N at edge E0 makes IFR[0] set at edge E0+N+1.
  - Example: N=0x0003 sets IFR[0] at E0+4.
  - In free-run mode the period is N+1 cycles.
- Pin latency:
  - A pin change appears in pin_sync after 2 edges.
  - IFR[1] sets on the 3rd edge after the falling pin transition.
  - irq_n falls right after that edge if IER[1]=1.
- Simultaneous events:
  - Underflow and IFR write-1-clear of bit0 on the same edge: set wins.
  - Pin edge and clear of bit1 on the same edge: set wins.
  - T_HI write on an underflow edge: the load wins and IFR[0] ends at 0.
  - T_LO read on an underflow edge: set wins.
- Counter wrap: CNT never decrements past 0. In one-shot mode, N=0 underflows on the first edge after the load.
- Reset during count: all state clears immediately, the timer stops, and irq_n=1 while rst_n=0 and after its release.
- cs_n=1: no side effects. addr, rw and data_in are ignored.

## Test plan
- Reset → port_out=0x00, port_oe=0x00, data_oe=0, irq_n=1. Reading addr 5 returns 0x00 and addr 6 returns 0x80.
- DDRA=0x0F, ORA=0xA5, port_in=0x30 held for ≥2 cycles → read addr 0 = 0x35, port_oe=0x0F, port_out=0xA5.
- One-shot timer:
  - Stimulus: IER write 0x81, T_LO=0x03, T_HI=0x00 at E0.
  - Response: irq_n falls after E0+4; CNT stays 0.
  - Then reading addr 2 returns 0x00 and irq_n returns to 1.
- Free-run timer:
  - Stimulus: ACR=0x01, latch 0x0002.
  - Response: IFR[0] sets every 3 cycles. After each set, write 0x01 to addr 5 to clear; an underflow on the same edge as the clear leaves IFR[0]=1.
- Pin edge: IER=0x82; drive port_in[0] 1→0 → irq_n=0 on the 3rd edge. A 0→1 transition sets nothing; writing 0x02 to addr 5 restores irq_n=1.
- Reset mid-count: load 0x1000, wait 10 cycles, pulse rst_n low asynchronously → CNT=0, no underflow ever occurs, irq_n=1.

Source files
------------

// File: rtl/io_timer_port.sv
// io_timer_port
// Purpose : memory-mapped I/O responder for the decoded I/O window. Provides an
//           8-bit GPIO port with per-bit direction, a 16-bit down-counting
//           timer (one-shot / free-run) and an interrupt flag/enable pair.
// Latency : writes take effect at the sampling edge. Reads are combinational
//           while data_oe=1. The timer flag sets N+1 edges after a T_HI load of N.
// Backpr. : none. Every selected access completes in the cycle it is presented.
//
// Ports
//   clk       in   1  system clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   cs_n      in   1  chip select from the address decoder, active low
//   rw        in   1  1 = read, 0 = write
//   addr      in   3  register index
//   data_in   in   8  CPU write data
//   data_out  out  8  read data, forced to 0x00 when not driving
//   data_oe   out  1  read-data drive enable
//   port_in   in   8  external pins, asynchronous to clk
//   port_out  out  8  output register (ORA)
//   port_oe   out  8  per-bit output enable (DDRA)
//   irq_n     out  1  interrupt request, active low
//
// Register map
//   0 ORA    1 DDRA   2 T_LO   3 T_HI   4 ACR   5 IFR   6 IER   7 reserved

module io_timer_port (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       rw,
  input  logic [2:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] port_in,
  output logic [7:0] port_out,
  output logic [7:0] port_oe,
  output logic       irq_n
);

  // Register indices
  localparam logic [2:0] A_ORA  = 3'd0;
  localparam logic [2:0] A_DDRA = 3'd1;
  localparam logic [2:0] A_TLO  = 3'd2;
  localparam logic [2:0] A_THI  = 3'd3;
  localparam logic [2:0] A_ACR  = 3'd4;
  localparam logic [2:0] A_IFR  = 3'd5;
  localparam logic [2:0] A_IER  = 3'd6;

  // Interrupt flag bit positions
  localparam int IF_TIMER = 0;
  localparam int IF_PIN   = 1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [7:0]  r_ora;
  logic [7:0]  r_ddra;
  logic [7:0]  r_latch_l;
  logic [7:0]  r_latch_h;
  logic [15:0] r_cnt;
  logic        r_running;
  logic        r_acr;        // only the free-run bit is stored
  logic [1:0]  r_ifr;
  logic [1:0]  r_ier;
  logic [7:0]  r_sync1;
  logic [7:0]  r_sync2;      // pin_sync
  logic        r_prev_pin0;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic w_wr;
  logic w_rd;
  logic w_wr_ora;
  logic w_wr_ddra;
  logic w_wr_tlo;
  logic w_wr_thi;
  logic w_wr_acr;
  logic w_wr_ifr;
  logic w_wr_ier;
  logic w_rd_tlo;

  assign w_wr      = ~cs_n & ~rw;
  assign w_rd      = ~cs_n &  rw;

  assign w_wr_ora  = w_wr & (addr == A_ORA);
  assign w_wr_ddra = w_wr & (addr == A_DDRA);
  assign w_wr_tlo  = w_wr & (addr == A_TLO);
  assign w_wr_thi  = w_wr & (addr == A_THI);
  assign w_wr_acr  = w_wr & (addr == A_ACR);
  assign w_wr_ifr  = w_wr & (addr == A_IFR);
  assign w_wr_ier  = w_wr & (addr == A_IER);
  assign w_rd_tlo  = w_rd & (addr == A_TLO);

  // --------------------------------------------------------------------------
  // Timer next state
  // --------------------------------------------------------------------------
  // A T_HI write pre-empts the countdown on the same edge, so an underflow
  // that coincides with a reload is suppressed entirely.
  logic        w_underflow;
  logic [15:0] w_cnt_nxt;
  logic        w_running_nxt;

  assign w_underflow = r_running & ~w_wr_thi & (r_cnt == 16'd0);

  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_running_nxt = r_running;
    if (w_wr_thi) begin
      w_cnt_nxt     = {data_in, r_latch_l};
      w_running_nxt = 1'b1;
    end else if (r_running) begin
      if (r_cnt != 16'd0) begin
        w_cnt_nxt = r_cnt - 16'd1;
      end else if (r_acr) begin
        w_cnt_nxt = {r_latch_h, r_latch_l};
      end else begin
        // One-shot: stop at zero, counter stays parked there.
        w_running_nxt = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Interrupt flags next state
  // --------------------------------------------------------------------------
  // Clears are applied first and sets last, so a hardware event on the same
  // edge as a software clear always leaves the flag set.
  logic       w_pin_fall;
  logic [1:0] w_ifr_nxt;

  assign w_pin_fall = r_prev_pin0 & ~r_sync2[0];

  always_comb begin
    w_ifr_nxt = r_ifr;
    if (w_wr_ifr) begin
      w_ifr_nxt = w_ifr_nxt & ~data_in[1:0];
    end
    if (w_rd_tlo | w_wr_thi) begin
      w_ifr_nxt[IF_TIMER] = 1'b0;
    end
    if (w_underflow) begin
      w_ifr_nxt[IF_TIMER] = 1'b1;
    end
    if (w_pin_fall) begin
      w_ifr_nxt[IF_PIN] = 1'b1;
    end
  end

  // IER uses set/clear semantics selected by data_in[7].
  logic [1:0] w_ier_nxt;

  always_comb begin
    w_ier_nxt = r_ier;
    if (w_wr_ier) begin
      if (data_in[7]) begin
        w_ier_nxt = r_ier | data_in[1:0];
      end else begin
        w_ier_nxt = r_ier & ~data_in[1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ora       <= 8'h00;
      r_ddra      <= 8'h00;
      r_latch_l   <= 8'h00;
      r_latch_h   <= 8'h00;
      r_cnt       <= 16'h0000;
      r_running   <= 1'b0;
      r_acr       <= 1'b0;
      r_ifr       <= 2'b00;
      r_ier       <= 2'b00;
      r_sync1     <= 8'h00;
      r_sync2     <= 8'h00;
      r_prev_pin0 <= 1'b0;
    end else begin
      // Two-flop synchronizer for the asynchronous pins, plus a history bit
      // on pin 0 for falling-edge detection.
      r_sync1     <= port_in;
      r_sync2     <= r_sync1;
      r_prev_pin0 <= r_sync2[0];

      if (w_wr_ora) begin
        r_ora <= data_in;
      end
      if (w_wr_ddra) begin
        r_ddra <= data_in;
      end
      if (w_wr_tlo) begin
        r_latch_l <= data_in;
      end
      if (w_wr_thi) begin
        r_latch_h <= data_in;
      end
      if (w_wr_acr) begin
        r_acr <= data_in[0];
      end

      r_cnt     <= w_cnt_nxt;
      r_running <= w_running_nxt;
      r_ifr     <= w_ifr_nxt;
      r_ier     <= w_ier_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  logic       w_irq_any;
  logic [7:0] w_rd_dat;

  assign w_irq_any = |(r_ifr & r_ier);

  always_comb begin
    w_rd_dat = 8'h00;
    case (addr)
      // Output bits reflect ORA, input bits reflect the synchronized pins.
      A_ORA:   w_rd_dat = (r_ora & r_ddra) | (r_sync2 & ~r_ddra);
      A_DDRA:  w_rd_dat = r_ddra;
      A_TLO:   w_rd_dat = r_cnt[7:0];
      A_THI:   w_rd_dat = r_cnt[15:8];
      A_ACR:   w_rd_dat = {7'b0, r_acr};
      A_IFR:   w_rd_dat = {w_irq_any, 5'b0, r_ifr};
      A_IER:   w_rd_dat = {1'b1, 5'b0, r_ier};
      default: w_rd_dat = 8'h00;
    endcase
  end

  assign data_oe  = w_rd;
  assign data_out = w_rd ? w_rd_dat : 8'h00;

  // --------------------------------------------------------------------------
  // Pin and interrupt outputs
  // --------------------------------------------------------------------------
  assign port_out = r_ora;
  assign port_oe  = r_ddra;

  // Pure function of registers, so the IRQ line cannot glitch on bus activity.
  assign irq_n = ~w_irq_any;

endmodule

// File: tb/tb_io_timer_port.sv
// tb_io_timer_port
// Purpose : directed bench for io_timer_port. Reads push their expected data
//           into a queue; a monitor pops and compares whenever data_oe is high.
// Timing  : inputs driven 1ns after the rising edge, read data sampled on the
//           falling edge, status pins checked 1ns after the rising edge.

module tb_io_timer_port;

  logic       clk;
  logic       rst_n;
  logic       cs_n;
  logic       rw;
  logic [2:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] port_in;
  logic [7:0] port_out;
  logic [7:0] port_oe;
  logic       irq_n;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  string      name_q[$];
  logic [7:0] mon_exp;
  string      mon_name;

  io_timer_port dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs_n     (cs_n),
    .rw       (rw),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .data_oe  (data_oe),
    .port_in  (port_in),
    .port_out (port_out),
    .port_oe  (port_oe),
    .irq_n    (irq_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", nm, act, exp);
    end
  endtask

  // Monitor: every presented read must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && data_oe) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_read: data_out 0x%02h, expected no read", data_out);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        cmp(mon_name, data_out, mon_exp);
      end
    end
  end

  // All bus tasks start 1ns after an edge and return 1ns after the edge
  // that sampled the access.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
    cs_n    = 1'b0;
    rw      = 1'b0;
    addr    = a;
    data_in = d;
    @(posedge clk);
    #1;
    cs_n    = 1'b1;
    rw      = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, input logic [7:0] exp, input string nm);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    cs_n = 1'b0;
    rw   = 1'b1;
    addr = a;
    @(posedge clk);
    #1;
    cs_n = 1'b1;
  endtask

  task automatic chk_irq(input string nm, input logic exp);
    cmp(nm, {7'b0, irq_n}, {7'b0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    cs_n    = 1'b1;
    rw      = 1'b1;
    addr    = 3'd0;
    data_in = 8'h00;
    port_in = 8'h00;

    // ---- reset state
    #12;
    cmp("rst_port_out", port_out, 8'h00);
    cmp("rst_port_oe",  port_oe,  8'h00);
    cmp("rst_data_oe",  {7'b0, data_oe}, 8'h00);
    cmp("rst_data_out", data_out, 8'h00);
    chk_irq("rst_irq_n", 1'b1);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    bus_rd(3'd5, 8'h00, "rst_ifr");
    bus_rd(3'd6, 8'h80, "rst_ier");
    bus_rd(3'd4, 8'h00, "rst_acr");
    bus_rd(3'd7, 8'h00, "rsvd_read");

    // ---- GPIO
    port_in = 8'h30;
    bus_wr(3'd1, 8'h0F);
    bus_wr(3'd0, 8'hA5);
    bus_rd(3'd0, 8'h35, "gpio_read");
    cmp("gpio_port_oe",  port_oe,  8'h0F);
    cmp("gpio_port_out", port_out, 8'hA5);
    // Unselected write must be ignored.
    cs_n = 1'b1; rw = 1'b0; addr = 3'd1; data_in = 8'hFF;
    idle(1);
    rw = 1'b1;
    bus_wr(3'd7, 8'hFF);
    bus_rd(3'd1, 8'h0F, "cs_n_high_no_write");
    bus_wr(3'd4, 8'hFE);
    bus_rd(3'd4, 8'h00, "acr_upper_not_stored");

    // ---- one-shot, N=3: flag at E0+4
    bus_wr(3'd6, 8'h81);
    bus_wr(3'd2, 8'h03);
    bus_wr(3'd3, 8'h00);               // E0
    bus_rd(3'd2, 8'h03, "os_cnt_e0");
    bus_rd(3'd2, 8'h02, "os_cnt_e1");
    idle(1);                           // E0+3
    chk_irq("os_irq_before", 1'b1);
    idle(1);                           // E0+4
    chk_irq("os_irq_fires", 1'b0);
    bus_rd(3'd5, 8'h81, "os_ifr");
    bus_rd(3'd3, 8'h00, "os_cnt_hi_zero");
    bus_rd(3'd2, 8'h00, "os_cnt_lo_zero");
    chk_irq("os_tlo_read_clears", 1'b1);
    bus_rd(3'd5, 8'h00, "os_ifr_cleared");

    // ---- free-run, latch 2: period 3
    bus_wr(3'd4, 8'h01);
    bus_rd(3'd4, 8'h01, "fr_acr");
    bus_wr(3'd2, 8'h02);
    bus_wr(3'd3, 8'h00);               // E0
    idle(3);                           // E0+3 underflow
    chk_irq("fr_first_period", 1'b0);
    bus_wr(3'd5, 8'h01);               // E0+4 clear
    chk_irq("fr_cleared", 1'b1);
    idle(1);
    bus_wr(3'd5, 8'h01);               // E0+6 clear on underflow edge
    chk_irq("fr_set_beats_clear", 1'b0);
    bus_rd(3'd5, 8'h81, "fr_ifr_set");
    bus_wr(3'd4, 8'h00);               // E0+8
    idle(1);                           // E0+9 last underflow, stops
    bus_wr(3'd5, 8'h01);
    chk_irq("fr_stopped_clear", 1'b1);
    bus_rd(3'd3, 8'h00, "fr_stop_hi");
    bus_rd(3'd2, 8'h00, "fr_stop_lo");
    idle(5);
    chk_irq("fr_stays_stopped", 1'b1);

    // ---- T_HI write on an underflow edge: load wins
    bus_wr(3'd2, 8'h01);
    bus_wr(3'd3, 8'h00);               // E0, CNT=1
    idle(1);                           // CNT=0
    bus_wr(3'd3, 8'h00);               // E0+2 would underflow
    chk_irq("thi_load_wins", 1'b1);
    bus_rd(3'd5, 8'h00, "thi_load_ifr");
    idle(1);                           // E0+4 underflow
    chk_irq("thi_reload_fires", 1'b0);
    bus_rd(3'd2, 8'h00, "thi_reload_clr");
    chk_irq("thi_reload_cleared", 1'b1);

    // ---- N=0 one-shot with a T_LO read on the underflow edge
    bus_wr(3'd2, 8'h00);
    bus_wr(3'd3, 8'h00);               // E0
    bus_rd(3'd2, 8'h00, "n0_read_on_uf");
    chk_irq("n0_set_beats_read", 1'b0);
    bus_rd(3'd2, 8'h00, "n0_clear_read");
    chk_irq("n0_cleared", 1'b1);

    // ---- pin 0 falling edge
    bus_wr(3'd6, 8'h01);
    bus_wr(3'd6, 8'h82);
    bus_rd(3'd6, 8'h82, "pin_ier");
    port_in = 8'h31;
    idle(3);
    chk_irq("pin_rise_no_irq", 1'b1);
    bus_rd(3'd5, 8'h00, "pin_rise_ifr");
    port_in = 8'h30;
    idle(2);
    chk_irq("pin_fall_edge2", 1'b1);
    idle(1);
    chk_irq("pin_fall_edge3", 1'b0);
    bus_rd(3'd5, 8'h82, "pin_ifr");
    bus_wr(3'd5, 8'h02);
    chk_irq("pin_cleared", 1'b1);
    port_in = 8'h31;
    idle(3);
    port_in = 8'h30;
    idle(2);
    bus_wr(3'd5, 8'h02);               // clear on the set edge
    chk_irq("pin_set_beats_clear", 1'b0);
    bus_wr(3'd5, 8'h02);
    chk_irq("pin_cleared2", 1'b1);

    // ---- asynchronous reset mid-count
    bus_wr(3'd6, 8'h81);
    bus_wr(3'd2, 8'h00);
    bus_wr(3'd3, 8'h10);               // E0, CNT=0x1000
    idle(10);
    bus_rd(3'd3, 8'h0F, "mid_cnt_hi");
    bus_rd(3'd2, 8'hF5, "mid_cnt_lo");
    #2;
    rst_n = 1'b0;
    #1;
    chk_irq("arst_irq_n", 1'b1);
    cmp("arst_port_out", port_out, 8'h00);
    cmp("arst_port_oe",  port_oe,  8'h00);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus_rd(3'd3, 8'h00, "arst_cnt_hi");
    bus_rd(3'd2, 8'h00, "arst_cnt_lo");
    bus_wr(3'd6, 8'h81);
    idle(20);
    chk_irq("arst_no_underflow", 1'b1);
    bus_rd(3'd5, 8'h00, "arst_ifr");
    bus_rd(3'd6, 8'h81, "arst_ier");
    bus_rd(3'd1, 8'h00, "arst_ddra");
    bus_rd(3'd0, 8'h30, "arst_pins");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d reads outstanding, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
